// File: rtl/sprite_animator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sprite_animator_pkg
// Purpose : Screen and sprite-sheet geometry plus the animation state
//           encodings shared by the sprite animator and the game logic.
// Contents: SCREEN_WIDTH, SPRITE_WIDTH, SPRITE_HEIGHT, SPRITE_PIXELS,
//           SPRITE_ADDR_DEPTH, MAX_X, anim_state_t
// Revision: 1.0 - initial release
// ============================================================================
package sprite_animator_pkg;

    localparam int SCREEN_WIDTH      = 640;
    localparam int SPRITE_WIDTH      = 32;
    localparam int SPRITE_HEIGHT     = 32;
    localparam int SPRITE_PIXELS     = SPRITE_WIDTH * SPRITE_HEIGHT;
    // Width of the sprite ROM address; one sheet holds idle + walk + punch frames
    localparam int SPRITE_ADDR_DEPTH = 13;
    // Rightmost legal left-edge x so the sprite never crosses the screen edge
    localparam int MAX_X             = SCREEN_WIDTH - SPRITE_WIDTH;

    typedef enum logic [1:0] {
        ANIM_IDLE  = 2'b00,
        ANIM_WALK  = 2'b01,
        ANIM_PUNCH = 2'b10
    } anim_state_t;

endpackage : sprite_animator_pkg
`default_nettype wire

// File: rtl/sprite_animator_frame_counter.sv
`default_nettype none
// ============================================================================
// Module  : anim_frame_counter
// Purpose : Holds each animation frame for FRAME_HOLD ticks, steps through a
//           sequence of i_len frames and keeps the ROM offset of the current
//           frame as a running sum (no multiplier).
// Ports   : clk, rst          clock / synchronous active-high reset
//           i_tick            advance hold counter (ignored when i_load)
//           i_load            restart sequence: frame 0, hold 0, offset=i_base
//           i_base            offset of first frame of the sequence
//           i_len             number of frames in the current sequence
//           o_offset          ROM base address of the current frame
//           o_last_frame      last frame of sequence and its last hold tick
// Revision: 1.0 - initial release
// ============================================================================
module anim_frame_counter
    import sprite_animator_pkg::*;
#(
    parameter int FRAME_HOLD = 6,
    parameter int MAX_LEN    = 4,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_tick,
    input  logic                         i_load,
    input  logic [SPRITE_ADDR_DEPTH-1:0] i_base,
    input  logic [LEN_W-1:0]             i_len,
    output logic [SPRITE_ADDR_DEPTH-1:0] o_offset,
    output logic                         o_last_frame
);

    localparam int HOLD_W = $clog2(FRAME_HOLD + 1);
    localparam logic [HOLD_W-1:0]            c_HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [SPRITE_ADDR_DEPTH-1:0] c_FRAME_STEP = SPRITE_ADDR_DEPTH'(SPRITE_PIXELS);

    logic [HOLD_W-1:0]            r_hold;
    logic [LEN_W-1:0]             r_idx;
    logic [SPRITE_ADDR_DEPTH-1:0] r_offset;
    logic                         w_hold_done;
    logic                         w_seq_end;

    assign w_hold_done  = (r_hold == c_HOLD_LAST);
    assign w_seq_end    = (r_idx == (i_len - LEN_W'(1)));
    assign o_offset     = r_offset;
    assign o_last_frame = w_hold_done & w_seq_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold   <= '0;
            r_idx    <= '0;
            r_offset <= '0;
        end else if (i_load) begin
            r_hold   <= '0;
            r_idx    <= '0;
            r_offset <= i_base;
        end else if (i_tick) begin
            if (w_hold_done) begin
                r_hold <= '0;
                // Past the last frame the sequence wraps back to its first frame
                if (w_seq_end) begin
                    r_idx    <= '0;
                    r_offset <= i_base;
                end else begin
                    r_idx    <= r_idx + LEN_W'(1);
                    r_offset <= r_offset + c_FRAME_STEP;
                end
            end else begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

endmodule : anim_frame_counter
`default_nettype wire

// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
// Module  : sprite_animator
// Purpose : Per-player motion/animation controller for the sprite renderer.
//           All state moves only on frame_tick so renderer inputs are stable
//           during active video.
// Ports   : clk, reset                      clock / synchronous active-high reset
//           frame_tick                      one-cycle pulse per video frame
//           move_left, move_right, punch    request levels, sampled on frame_tick
//           sprite_position [9:0]           sprite left x, 0..MAX_X
//           addr_offset [SPRITE_ADDR_DEPTH] ROM base address of current frame
//           anim_state [1:0]                00 IDLE, 01 WALK, 10 PUNCH
//           busy                            high while punching
// Revision: 1.0 - initial release
// ============================================================================
module sprite_animator
    import sprite_animator_pkg::*;
#(
    parameter int START_X      = 100,
    parameter int STEP_PX      = 2,
    parameter int FRAME_HOLD   = 6,
    parameter int WALK_FRAMES  = 4,
    parameter int PUNCH_FRAMES = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         move_left,
    input  logic                         move_right,
    input  logic                         punch,
    output logic [9:0]                   sprite_position,
    output logic [SPRITE_ADDR_DEPTH-1:0] addr_offset,
    output logic [1:0]                   anim_state,
    output logic                         busy
);

    localparam int AW      = SPRITE_ADDR_DEPTH;
    localparam int MAX_LEN = (WALK_FRAMES > PUNCH_FRAMES) ? WALK_FRAMES : PUNCH_FRAMES;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    localparam logic [AW-1:0]    c_BASE_WALK  = AW'(SPRITE_PIXELS);
    localparam logic [AW-1:0]    c_BASE_PUNCH = AW'((WALK_FRAMES + 1) * SPRITE_PIXELS);
    localparam logic [LEN_W-1:0] c_LEN_WALK   = LEN_W'(WALK_FRAMES);
    localparam logic [LEN_W-1:0] c_LEN_PUNCH  = LEN_W'(PUNCH_FRAMES);
    // Position arithmetic is one bit wider than the port so the clamp never wraps
    localparam logic [10:0]      c_STEP       = 11'(STEP_PX);
    localparam logic [10:0]      c_MAX_X      = 11'(MAX_X);
    localparam logic [10:0]      c_START_X    = 11'(START_X);

    if ((1 + WALK_FRAMES + PUNCH_FRAMES) * SPRITE_PIXELS > (1 << SPRITE_ADDR_DEPTH)) begin : g_addr_fit_check
        $error("sprite sheet does not fit in SPRITE_ADDR_DEPTH address bits");
    end
    if (FRAME_HOLD < 1) begin : g_hold_check
        $error("FRAME_HOLD must be at least 1");
    end

    anim_state_t      r_state;
    anim_state_t      w_state_nxt;
    anim_state_t      w_req;
    logic [10:0]      r_pos;
    logic [10:0]      w_pos_nxt;
    logic [10:0]      w_pos_left;
    logic [10:0]      w_pos_right;
    logic             r_busy;
    logic             w_load;
    logic             w_advance;
    logic             w_last;
    logic [AW-1:0]    w_base;
    logic [LEN_W-1:0] w_len;
    logic [AW-1:0]    w_offset;

    assign w_pos_left  = (r_pos < c_STEP) ? 11'd0 : (r_pos - c_STEP);
    assign w_pos_right = (r_pos > (c_MAX_X - c_STEP)) ? c_MAX_X : (r_pos + c_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ANIM_IDLE;
            r_pos   <= c_START_X;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_busy  <= (w_state_nxt == ANIM_PUNCH);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_base      = '0;
        w_len       = LEN_W'(1);

        // Punch has priority; conflicting left+right reads as no request
        if (punch) begin
            w_req = ANIM_PUNCH;
        end else if (move_left ^ move_right) begin
            w_req = ANIM_WALK;
        end else begin
            w_req = ANIM_IDLE;
        end

        if (frame_tick) begin
            case (r_state)
                // Idle reloads every tick so the pose stays on frame 0
                ANIM_IDLE: begin
                    w_state_nxt = w_req;
                    w_load      = 1'b1;
                end
                ANIM_WALK: begin
                    if (w_req == ANIM_WALK) begin
                        w_advance = 1'b1;
                    end else begin
                        w_state_nxt = w_req;
                        w_load      = 1'b1;
                    end
                end
                // Punch runs to completion; requests are only looked at on its final tick
                ANIM_PUNCH: begin
                    if (w_last) begin
                        w_state_nxt = w_req;
                        w_load      = 1'b1;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ANIM_IDLE;
                    w_load      = 1'b1;
                end
            endcase

            // Walking moves on every walking tick, the entry tick included
            if (w_state_nxt == ANIM_WALK) begin
                w_pos_nxt = move_left ? w_pos_left : w_pos_right;
            end
        end

        // Base always follows the state being entered/kept, so a walk wrap
        // lands back on the first walk frame
        case (w_state_nxt)
            ANIM_WALK:  w_base = c_BASE_WALK;
            ANIM_PUNCH: w_base = c_BASE_PUNCH;
            default:    w_base = '0;
        endcase

        case (r_state)
            ANIM_WALK:  w_len = c_LEN_WALK;
            ANIM_PUNCH: w_len = c_LEN_PUNCH;
            default:    w_len = LEN_W'(1);
        endcase
    end

    anim_frame_counter #(
        .FRAME_HOLD (FRAME_HOLD),
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W)
    ) u_frame_counter (
        .clk          (clk),
        .rst          (reset),
        .i_tick       (w_advance),
        .i_load       (w_load),
        .i_base       (w_base),
        .i_len        (w_len),
        .o_offset     (w_offset),
        .o_last_frame (w_last)
    );

    assign sprite_position = r_pos[9:0];
    assign addr_offset     = w_offset;
    assign anim_state      = r_state;
    assign busy            = r_busy;

endmodule : sprite_animator
`default_nettype wire
